// File: rtl/mem_copier.sv
// Bus master for a shared single-port memory: COPY, FILL or SUM over a
// contiguous wrap-around address range, sourcing/sinking the tri-state data bus.
module mem_copier #(
    parameter int DW = 16,
    parameter int W  = 256,
    parameter int AW = $clog2(W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    inout  tri logic [DW-1:0] data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_COPY = 2'd0;
    localparam logic [1:0] OP_FILL = 2'd1;
    localparam logic [1:0] OP_RSVD = 2'd3;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic [AW:0]   r_i;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_sum;
    logic          r_busy;
    logic          r_done;
    logic          r_re;
    logic          r_we;
    logic [AW-1:0] r_addr;

    logic [AW:0]   w_i_next;
    logic          w_last;
    logic [AW-1:0] w_src_next;
    logic [AW-1:0] w_dst_cur;
    logic [AW-1:0] w_dst_next;

    // Addresses are AW bits wide, so the additions wrap mod W on their own.
    assign w_i_next   = r_i + {{AW{1'b0}}, 1'b1};
    assign w_last     = (w_i_next == r_len);
    assign w_src_next = r_src + w_i_next[AW-1:0];
    assign w_dst_cur  = r_dst + r_i[AW-1:0];
    assign w_dst_next = r_dst + w_i_next[AW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: only control state and visible outputs are reset; the command
            // registers are reloaded on every accepted start before they are used.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sum   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_src   <= src;
                        r_dst   <= dst;
                        r_len   <= len;
                        r_i     <= '0;
                        r_sum   <= '0;
                        r_wdata <= fill_val;
                        if (len == '0 || op == OP_RSVD) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (op == OP_FILL) begin
                            r_state <= S_WRITE;
                            r_busy  <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= dst;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_re    <= 1'b1;
                            r_addr  <= src;
                        end
                    end
                end

                S_READ: begin
                    if (r_op == OP_COPY) begin
                        r_wdata <= data;
                        r_state <= S_WRITE;
                        r_re    <= 1'b0;
                        r_we    <= 1'b1;
                        r_addr  <= w_dst_cur;
                    end else begin
                        r_sum <= r_sum + data;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_re    <= 1'b0;
                            r_addr  <= '0;
                        end else begin
                            r_i    <= w_i_next;
                            r_addr <= w_src_next;
                        end
                    end
                end

                S_WRITE: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_i <= w_i_next;
                        if (r_op == OP_FILL) begin
                            r_addr <= w_dst_next;
                        end else begin
                            r_state <= S_READ;
                            r_we    <= 1'b0;
                            r_re    <= 1'b1;
                            r_addr  <= w_src_next;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign mem_re   = r_re;
    assign mem_we   = r_we;
    assign mem_addr = r_addr;
    assign data     = r_we ? r_wdata : {DW{1'bz}};

endmodule

// File: tb/tb_mem_copier.sv
// Self-checking bench for mem_copier: behavioural memory on the shared bus and
// a scoreboard of expected bus reads/writes filled as each command is issued.
module tb_mem_copier;

    localparam int DW = 16;
    localparam int W  = 256;
    localparam int AW = 8;
    localparam int BUDGET = 600;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_val;
    logic          busy;
    logic          done;
    logic [DW-1:0] sum;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    tri   [DW-1:0] data;

    logic [DW-1:0] mem [W];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_wdata;
    logic          probe_en;
    logic [DW-1:0] probe_val;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } wr_t;

    wr_t           wr_q [$];
    logic [AW-1:0] rd_q [$];
    int            n_checks;
    int            n_errors;

    mem_copier #(.DW(DW), .W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .data     (data)
    );

    always #5 clock = ~clock;

    // Combinational-read memory; the probe lets the bench test bus release.
    assign data = mem_re ? mem[mem_addr] : {DW{1'bz}};
    assign data = probe_en ? probe_val : {DW{1'bz}};

    always @(posedge clock) begin
        if (tb_we)
            mem[tb_addr] <= tb_wdata;
        else if (mem_we)
            mem[mem_addr] <= data;
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        tb_we    = 1'b1;
        tb_addr  = a;
        tb_wdata = v;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    // Drives the command so the next edge samples it; returns in cycle t+1.
    task automatic issue(input logic [1:0] o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [DW-1:0] f);
        op       = o;
        src      = s;
        dst      = d;
        len      = l;
        fill_val = f;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Monitors cycles t+1.. against the scoreboard until done, a reset cycle or the budget.
    task automatic run(input int pulse_cyc, input int rst_cyc, output int done_cyc, output int busy_cnt);
        wr_t w;
        logic [AW-1:0] ra;
        done_cyc = 0;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            n_checks++;
            if (mem_re && mem_we) begin
                n_errors++;
                $display("FAIL bus_conflict: cycle %0d re=%b we=%b, required not both high", cyc, mem_re, mem_we);
            end
            if (mem_we) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write", mem_addr, data);
                end else begin
                    w = wr_q.pop_front();
                    if (mem_addr !== w.addr || data !== w.val) begin
                        n_errors++;
                        $display("FAIL write: addr %h data %h, required addr %h data %h", mem_addr, data, w.addr, w.val);
                    end
                end
            end
            if (mem_re) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_read: addr %h, required no read", mem_addr);
                end else begin
                    ra = rd_q.pop_front();
                    if (mem_addr !== ra) begin
                        n_errors++;
                        $display("FAIL read_addr: got %h, required %h", mem_addr, ra);
                    end
                end
            end
            if (busy) busy_cnt++;
            if (cyc == rst_cyc) begin
                reset    = 1'b1;
                done_cyc = -1;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == pulse_cyc);
            @(negedge clock);
        end
        start = 1'b0;
        if (done_cyc == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no done within %0d cycles", BUDGET);
        end
    endtask

    task automatic check_queues_empty(input string name);
        n_checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_pending: writes left %0d reads left %0d, required 0 0", name, wr_q.size(), rd_q.size());
        end
        wr_q.delete();
        rd_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({busy, done, mem_re, mem_we} !== 4'b0 || mem_addr !== '0 || sum !== '0) begin
            n_errors++;
            $display("FAIL %s: busy %b done %b re %b we %b addr %h sum %h, required all 0",
                     name, busy, done, mem_re, mem_we, mem_addr, sum);
        end
        probe_en  = 1'b1;
        probe_val = 16'h1234;
        #1;
        n_checks++;
        if (data !== 16'h1234) begin
            n_errors++;
            $display("FAIL %s_bus_release: bus %h, required probe value 1234", name, data);
        end
        probe_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("after_reset");
    endtask

    task automatic test_copy();
        int dc, bc;
        for (int k = 0; k < 4; k++) begin
            poke(8'h10 + 8'(k), 16'h00A0 + 16'(k));
            poke(8'h80 + 8'(k), 16'h0000);
            rd_q.push_back(8'h10 + 8'(k));
            wr_q.push_back('{addr: 8'h80 + 8'(k), val: 16'h00A0 + 16'(k)});
        end
        issue(2'd0, 8'h10, 8'h80, 9'd4, 16'h0);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 9) begin n_errors++; $display("FAIL copy_done_cycle: got %0d, required 9", dc); end
        n_checks++;
        if (bc !== 8) begin n_errors++; $display("FAIL copy_busy_cycles: got %0d, required 8", bc); end
        check_queues_empty("copy");
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL copy_done_pulse: done %b busy %b after done cycle, required 0 0", done, busy);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem[8'h80 + 8'(k)] !== 16'h00A0 + 16'(k)) begin
                n_errors++;
                $display("FAIL copy_mem: addr %h holds %h, required %h", 8'h80 + 8'(k), mem[8'h80 + 8'(k)], 16'h00A0 + 16'(k));
            end
        end
    endtask

    task automatic test_fill_wrap();
        int dc, bc;
        logic [AW-1:0] a;
        poke(8'h01, 16'h1111);
        a = 8'hFE;
        for (int k = 0; k < 3; k++) begin
            poke(a, 16'h0000);
            wr_q.push_back('{addr: a, val: 16'h5A5A});
            a = a + 8'd1;
        end
        issue(2'd1, 8'h00, 8'hFE, 9'd3, 16'h5A5A);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 4 || bc !== 3) begin
            n_errors++;
            $display("FAIL fill_timing: done cycle %0d busy %0d, required 4 3", dc, bc);
        end
        check_queues_empty("fill");
        @(negedge clock);
        n_checks++;
        if (mem[8'hFE] !== 16'h5A5A || mem[8'hFF] !== 16'h5A5A || mem[8'h00] !== 16'h5A5A) begin
            n_errors++;
            $display("FAIL fill_mem: fe %h ff %h 00 %h, required 5a5a each", mem[8'hFE], mem[8'hFF], mem[8'h00]);
        end
        n_checks++;
        if (mem[8'h01] !== 16'h1111) begin
            n_errors++;
            $display("FAIL fill_untouched: addr 01 holds %h, required 1111", mem[8'h01]);
        end
    endtask

    task automatic test_sum();
        int dc, bc;
        poke(8'h20, 16'hFFFF);
        poke(8'h21, 16'h0002);
        poke(8'h22, 16'h0001);
        for (int k = 0; k < 3; k++) rd_q.push_back(8'h20 + 8'(k));
        issue(2'd2, 8'h20, 8'h00, 9'd3, 16'h0);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 4 || sum !== 16'h0002) begin
            n_errors++;
            $display("FAIL sum_done: done cycle %0d sum %h, required 4 0002", dc, sum);
        end
        check_queues_empty("sum");
        repeat (3) @(negedge clock);
        n_checks++;
        if (sum !== 16'h0002) begin
            n_errors++;
            $display("FAIL sum_hold: got %h, required 0002", sum);
        end
    endtask

    task automatic test_degenerate();
        int dc, bc;
        issue(2'd3, 8'h20, 8'h40, 9'd5, 16'h0);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 1 || bc !== 0 || sum !== 16'h0000) begin
            n_errors++;
            $display("FAIL reserved_op: done cycle %0d busy %0d sum %h, required 1 0 0000", dc, bc, sum);
        end
        check_queues_empty("reserved_op");
        @(negedge clock);
        issue(2'd0, 8'h10, 8'h80, 9'd0, 16'h0);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 1 || bc !== 0 || sum !== 16'h0000) begin
            n_errors++;
            $display("FAIL zero_len: done cycle %0d busy %0d sum %h, required 1 0 0000", dc, bc, sum);
        end
        check_queues_empty("zero_len");
        @(negedge clock);
    endtask

    task automatic test_start_ignored();
        int dc, bc;
        poke(8'h60, 16'h0000);
        poke(8'h61, 16'h0000);
        poke(8'h46, 16'h0777);
        for (int k = 0; k < 6; k++) wr_q.push_back('{addr: 8'h40 + 8'(k), val: 16'hBEEF});
        issue(2'd1, 8'h00, 8'h40, 9'd6, 16'hBEEF);
        op       = 2'd1;
        dst      = 8'h60;
        len      = 9'd2;
        fill_val = 16'hDEAD;
        run(3, 0, dc, bc);
        n_checks++;
        if (dc !== 7 || bc !== 6) begin
            n_errors++;
            $display("FAIL ignored_start_timing: done cycle %0d busy %0d, required 7 6", dc, bc);
        end
        check_queues_empty("ignored_start");
        repeat (3) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || mem[8'h60] !== 16'h0000 || mem[8'h46] !== 16'h0777) begin
            n_errors++;
            $display("FAIL ignored_start_image: busy %b 60=%h 46=%h, required 0 0000 0777", busy, mem[8'h60], mem[8'h46]);
        end
    endtask

    task automatic test_reset_mid_copy();
        int dc, bc;
        for (int k = 0; k < 4; k++) begin
            poke(8'h30 + 8'(k), 16'h00C0 + 16'(k));
            poke(8'h90 + 8'(k), 16'h0000);
        end
        rd_q.push_back(8'h30);
        rd_q.push_back(8'h31);
        wr_q.push_back('{addr: 8'h90, val: 16'h00C0});
        issue(2'd0, 8'h30, 8'h90, 9'd4, 16'h0);
        run(0, 3, dc, bc);
        @(negedge clock);
        check_idle_outputs("reset_mid");
        check_queues_empty("reset_mid");
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mem[8'h90] !== 16'h00C0 || mem[8'h91] !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_mid_mem: 90=%h 91=%h, required 00c0 0000", mem[8'h90], mem[8'h91]);
        end
        for (int k = 0; k < 2; k++) begin
            poke(8'hA0 + 8'(k), 16'h0000);
            rd_q.push_back(8'h30 + 8'(k));
            wr_q.push_back('{addr: 8'hA0 + 8'(k), val: 16'h00C0 + 16'(k)});
        end
        issue(2'd0, 8'h30, 8'hA0, 9'd2, 16'h0);
        run(0, 0, dc, bc);
        n_checks++;
        if (dc !== 5 || bc !== 4) begin
            n_errors++;
            $display("FAIL after_reset_copy: done cycle %0d busy %0d, required 5 4", dc, bc);
        end
        check_queues_empty("after_reset_copy");
        @(negedge clock);
        n_checks++;
        if (mem[8'hA0] !== 16'h00C0 || mem[8'hA1] !== 16'h00C1) begin
            n_errors++;
            $display("FAIL after_reset_mem: a0=%h a1=%h, required 00c0 00c1", mem[8'hA0], mem[8'hA1]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'd0;
        src       = '0;
        dst       = '0;
        len       = '0;
        fill_val  = '0;
        tb_we     = 1'b0;
        tb_addr   = '0;
        tb_wdata  = '0;
        probe_en  = 1'b0;
        probe_val = '0;
        @(negedge clock);
        test_reset();
        test_copy();
        test_fill_wrap();
        test_sum();
        test_degenerate();
        test_start_ignored();
        test_reset_mid_copy();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
